// File: rtl/score_digit_sequencer_if.sv
// Score/digit handshake bundle between the score counter (master) and the digit sequencer (slave).
interface score_digit_sequencer_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) ();
    logic                  score_valid;
    logic [BIN_W-1:0]      score;
    logic                  score_ready;
    logic [4*DIGITS-1:0]   digit_values;
    logic                  overflow;
    logic                  done;

    modport master (
        output score_valid,
        output score,
        input  score_ready,
        input  digit_values,
        input  overflow,
        input  done
    );

    modport slave (
        input  score_valid,
        input  score,
        output score_ready,
        output digit_values,
        output overflow,
        output done
    );
endinterface

// File: rtl/score_digit_sequencer.sv
// Sequential double-dabble binary-to-BCD converter feeding the HEX digit decoders.
// Optional leading-zero blanking of upper digits: define SCORE_LEADING_ZERO_BLANK_EN.
module score_digit_sequencer #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    score_digit_sequencer_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] SAT_MAX = max_value(DIGITS);

    function automatic logic is_over(input logic [BIN_W-1:0] v);
        return 64'(v) > SAT_MAX;
    endfunction

    function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
        if (is_over(v)) begin
            return SAT_MAX[BIN_W-1:0];
        end
        return v;
    endfunction

    // Double-dabble correction: any nibble that would reach 10+ after the shift is pre-biased by 3.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            nib = b[4*i +: 4];
            if (nib >= 4'd5) begin
                r[4*i +: 4] = nib + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] publish(input logic [BCD_W-1:0] b);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = b;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (b[4*i +: 4] == 4'h0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
`else
        return b;
`endif
    endfunction

    function automatic logic [BCD_W-1:0] reset_digits();
        logic [BCD_W-1:0] r;
        r = '0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    localparam logic [BCD_W-1:0] RST_DIGITS = reset_digits();

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              ready;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [BIN_W-1:0]  bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  digits_q;
    logic              overflow_q;
    logic              done_q;
    logic              accept;

    assign accept = (state_q == IDLE) && bus.score_valid;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.score_valid) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= RST_DIGITS;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.score_valid) begin
                        cnt_q <= CNT_W'(BIN_W);
                        ovf_q <= is_over(bus.score);
                    end
                end
                CONVERT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                PUBLISH: begin
                    digits_q   <= publish(bcd_q);
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Shift datapath: carries no reset, it is always reloaded on the accepting edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_q <= saturate(bus.score);
            bcd_q <= '0;
        end else if (state_q == CONVERT) begin
            {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
        end
    end

    assign bus.score_ready  = ready;
    assign bus.digit_values = digits_q;
    assign bus.overflow     = overflow_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed bench for score_digit_sequencer: decimal-arithmetic reference model checked every cycle plus literal expectations.
module tb_score_digit_sequencer;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = BIN_W + 1;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam logic [15:0] RST  = 16'hFFF0;
    localparam logic [15:0] E42  = 16'hFF42;
    localparam logic [15:0] E500 = 16'hF500;
    localparam logic [15:0] E77  = 16'hFF77;
    localparam logic [15:0] E305 = 16'hF305;
    localparam logic [15:0] E0   = 16'hFFF0;
    localparam logic [15:0] E9   = 16'hFFF9;
    localparam logic [15:0] E10  = 16'hFF10;
    localparam logic [15:0] E99  = 16'hFF99;
    localparam logic [15:0] E100 = 16'hF100;
`else
    localparam logic [15:0] RST  = 16'h0000;
    localparam logic [15:0] E42  = 16'h0042;
    localparam logic [15:0] E500 = 16'h0500;
    localparam logic [15:0] E77  = 16'h0077;
    localparam logic [15:0] E305 = 16'h0305;
    localparam logic [15:0] E0   = 16'h0000;
    localparam logic [15:0] E9   = 16'h0009;
    localparam logic [15:0] E10  = 16'h0010;
    localparam logic [15:0] E99  = 16'h0099;
    localparam logic [15:0] E100 = 16'h0100;
`endif

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    score_digit_sequencer_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    score_digit_sequencer #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display word from plain decimal arithmetic.
    function automatic logic [15:0] exp_digits(input int v);
        int          s;
        int          d;
        int          p;
        logic [15:0] r;
        bit          lead;
        s    = (v > 9999) ? 9999 : v;
        r    = 16'h0;
        lead = 1'b1;
        p    = 1000;
        for (int i = 3; i >= 0; i--) begin
            d = (s / p) % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            if (i > 0 && lead && d == 0) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                r[4*i +: 4] = 4'(d);
                lead = 1'b0;
            end
`else
            r[4*i +: 4] = 4'(d);
`endif
            p = p / 10;
        end
        return r;
    endfunction

    // Reference model: a countdown to the publish edge, counted from each accepted score.
    int          m_busy = 0;
    int          m_pend = 0;
    bit          m_povf = 1'b0;
    logic [15:0] m_dig  = RST;
    bit          m_ovf  = 1'b0;
    bit          m_done = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_dig  <= RST;
        end else if (m_busy == 0) begin
            m_done <= 1'b0;
            if (bus.score_valid) begin
                m_busy <= LAT;
                m_pend <= int'(bus.score);
                m_povf <= (int'(bus.score) > 9999);
            end
        end else begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_dig  <= exp_digits(m_pend);
                m_ovf  <= m_povf;
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("ready",    16'(bus.score_ready), 16'(m_busy == 0));
        chk("done",     16'(bus.done),        16'(m_done));
        chk("digits",   bus.digit_values,     m_dig);
        chk("overflow", 16'(bus.overflow),    16'(m_ovf));
    endtask

    task automatic offer(input int v);
        bus.score       = 14'(v);
        bus.score_valid = 1'b1;
        tick();
        bus.score_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (n < 40 && !seen) begin
            tick();
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("wait_done", 16'd0, 16'd1);
    endtask

    int          n;
    int          sw [6] = '{0, 9, 10, 99, 100, 9999};
    logic [15:0] se [6];

    initial begin
        se = '{E0, E9, E10, E99, E100, 16'h9999};
        reset           = 1'b1;
        bus.score_valid = 1'b0;
        bus.score       = '0;
        @(posedge clk);
        tick();
        tick();
        chk("rst_ready",  16'(bus.score_ready), 16'd1);
        chk("rst_done",   16'(bus.done),        16'd0);
        chk("rst_ovf",    16'(bus.overflow),    16'd0);
        chk("rst_digits", bus.digit_values,     RST);
        reset = 1'b0;
        tick();

        // Basic conversion with exact latency and output hold.
        offer(1234);
        bus.score = 14'd8888;
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            chk("hold_digits", bus.digit_values, RST);
            chk("hold_done",   16'(bus.done),    16'd0);
        end
        tick();
        chk("lat_done", 16'(bus.done),    16'd1);
        chk("d1234",    bus.digit_values, 16'h1234);
        chk("ovf1234",  16'(bus.overflow), 16'd0);
        tick();

        // Saturation, then a small value clears overflow.
        offer(16383);
        wait_done(n);
        chk("lat_sat", 16'(n), 16'(LAT));
        chk("d_sat",   bus.digit_values,  16'h9999);
        chk("ovf_sat", 16'(bus.overflow), 16'd1);
        offer(42);
        wait_done(n);
        chk("d42",   bus.digit_values,  E42);
        chk("ovf42", 16'(bus.overflow), 16'd0);

        // Busy ignore, then acceptance on the done cycle.
        offer(500);
        bus.score       = 14'd77;
        bus.score_valid = 1'b1;
        wait_done(n);
        chk("lat500", 16'(n), 16'(LAT));
        chk("d500",   bus.digit_values, E500);
        tick();
        bus.score_valid = 1'b0;
        wait_done(n);
        chk("lat77", 16'(n), 16'(LAT));
        chk("d77",   bus.digit_values, E77);

        // Reset in the middle of a conversion.
        offer(16383);
        wait_done(n);
        offer(9876);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        chk("mid_ready",  16'(bus.score_ready), 16'd1);
        chk("mid_done",   16'(bus.done),        16'd0);
        chk("mid_ovf",    16'(bus.overflow),    16'd0);
        chk("mid_digits", bus.digit_values,     RST);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mid_nodone", 16'(bus.done), 16'd0);
        end
        offer(305);
        wait_done(n);
        chk("lat305", 16'(n), 16'(LAT));
        chk("d305",   bus.digit_values, E305);

        // Back-to-back sweep offered on each done cycle.
        bus.score       = 14'(sw[0]);
        bus.score_valid = 1'b1;
        tick();
        bus.score_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wait_done(n);
            chk("sweep_lat", 16'(n), 16'(LAT));
            chk("sweep_d",   bus.digit_values, se[k-1]);
            if (k < 6) begin
                bus.score       = 14'(sw[k]);
                bus.score_valid = 1'b1;
                tick();
                bus.score_valid = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
